// File: rtl/pipe_gen_pkg.sv
// pipe_gen_pkg: shared FSM state type and LFSR feedback taps for the pipe stream generator.
package pipe_gen_pkg;

    typedef enum logic [1:0] {IDLE, LEAD, PIPE, SPACE} state_e;

    // Maximal-length feedback taps, bit (n-1) set for tap n.
    function automatic logic [15:0] lfsr_taps(input int unsigned w);
        case (w)
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h00B8;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// lfsr_gen: free-running Fibonacci LFSR that reloads its seed if it ever locks at zero.
module lfsr_gen
    import pipe_gen_pkg::*;
#(
    parameter int unsigned          LFSR_W = 8,
    parameter logic [LFSR_W-1:0]    SEED   = 8'hA5,
    parameter int unsigned          OUT_W  = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [OUT_W-1:0] raw_o
);

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    assign lfsr_d = (lfsr_q == '0) ? SEED : {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
    assign raw_o  = lfsr_q[OUT_W-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= SEED;
        else         lfsr_q <= lfsr_d;
    end

endmodule

// File: rtl/pipe_stream_gen.sv
// pipe_stream_gen: scrolling column stream of random-gap pipes and spacing for the LED matrix.
module pipe_stream_gen
    import pipe_gen_pkg::*;
#(
    parameter int unsigned       ROWS       = 16,
    parameter int unsigned       GAP_MAX    = 6,
    parameter int unsigned       GAP_MIN    = 3,
    parameter int unsigned       PIPE_WIDTH = 2,
    parameter int unsigned       SPACING    = 3,
    parameter int unsigned       MAX_STEP   = 4,
    parameter int unsigned       LFSR_W     = 8,
    parameter logic [LFSR_W-1:0] SEED       = 8'hA5,
    parameter int unsigned       CNT_W      = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic                    tick_i,
    input  logic [1:0]              mode_i,
    output logic [ROWS-1:0]         column_o,
    output logic                    column_valid_o,
    output logic                    pipe_start_o,
    output logic [$clog2(ROWS)-1:0] gap_pos_o,
    output logic [CNT_W-1:0]        pipes_emitted_o
);

    localparam int unsigned PW = $clog2(ROWS);
    localparam int unsigned AW = $clog2(ROWS + MAX_STEP + 1) + 1;
    localparam int unsigned CW = $clog2((SPACING > PIPE_WIDTH ? SPACING : PIPE_WIDTH) + 1);

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [ROWS-1:0]   column_q, column_d;
    logic              valid_q, start_q;
    logic [PW-1:0]     gap_pos_q, pos_d, raw;
    logic [CNT_W-1:0]  pipes_q, pipes_d;
    logic [AW-1:0]     gap, max_pos, cand, lo, hi, stepped;

    lfsr_gen #(.LFSR_W(LFSR_W), .SEED(SEED), .OUT_W(PW)) u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .raw_o  (raw)
    );

    // Out-of-range raw values fold back into [0, max_pos] rather than being rejected.
    always_comb begin
        gap      = (AW'(GAP_MAX) < AW'(GAP_MIN) + AW'(mode_i)) ? AW'(GAP_MIN) : AW'(GAP_MAX) - AW'(mode_i);
        max_pos  = AW'(ROWS) - gap;
        cand     = (AW'(raw) > max_pos) ? AW'(raw) - max_pos - 1'b1 : AW'(raw);
        lo       = (AW'(gap_pos_q) > AW'(MAX_STEP)) ? AW'(gap_pos_q) - AW'(MAX_STEP) : '0;
        hi       = AW'(gap_pos_q) + AW'(MAX_STEP);
        stepped  = (cand < lo) ? lo : ((cand > hi) ? hi : cand);
        pos_d    = PW'((stepped > max_pos) ? max_pos : stepped);
        column_d = ~(((ROWS'(1) << gap) - ROWS'(1)) << pos_d);
        pipes_d  = (&pipes_q) ? pipes_q : pipes_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            column_q  <= '0;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
            gap_pos_q <= '0;
            pipes_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            start_q <= 1'b0;
            if (!enable_i) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                column_q <= '0;
            end else if (tick_i) begin
                valid_q  <= 1'b1;
                cnt_q    <= cnt_q + 1'b1;
                column_q <= '0;
                case (state_q)
                    IDLE: begin
                        state_q   <= LEAD;
                        cnt_q     <= CW'(1);
                        pipes_q   <= '0;
                        gap_pos_q <= PW'((ROWS - GAP_MAX) / 2);
                    end
                    LEAD, SPACE: begin
                        if (cnt_q == CW'(SPACING)) begin
                            state_q   <= PIPE;
                            cnt_q     <= CW'(1);
                            column_q  <= column_d;
                            gap_pos_q <= pos_d;
                            start_q   <= 1'b1;
                            if (PIPE_WIDTH == 1) pipes_q <= pipes_d;
                        end
                    end
                    PIPE: begin
                        if (cnt_q == CW'(PIPE_WIDTH)) begin
                            state_q <= SPACE;
                            cnt_q   <= CW'(1);
                        end else begin
                            column_q <= column_q;
                            if (cnt_q == CW'(PIPE_WIDTH - 1)) pipes_q <= pipes_d;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign column_o        = column_q;
    assign column_valid_o  = valid_q;
    assign pipe_start_o    = start_q;
    assign gap_pos_o       = gap_pos_q;
    assign pipes_emitted_o = pipes_q;

endmodule

// File: tb/tb_pipe_stream_gen.sv
// tb_pipe_stream_gen: directed vector table, corner sequences and random ticks against a column-index reference model.
module tb_pipe_stream_gen;

    localparam int ROWS = 16, PIPE_W = 2, SPC = 3;

    logic        clk = 0, rst_n = 0, enable = 0, tick = 0;
    logic [1:0]  mode = 0;
    logic [15:0] column;
    logic        column_valid, pipe_start;
    logic [3:0]  gap_pos;
    logic [7:0]  pipes;
    int          total = 0, bad = 0;
    bit          chk_en = 0;

    always #5 clk = ~clk;

    pipe_stream_gen dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .enable_i        (enable),
        .tick_i          (tick),
        .mode_i          (mode),
        .column_o        (column),
        .column_valid_o  (column_valid),
        .pipe_start_o    (pipe_start),
        .gap_pos_o       (gap_pos),
        .pipes_emitted_o (pipes)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic tk);
        enable = en;
        tick   = tk;
        @(posedge clk);
        #1 tick = 0;
    endtask

    function automatic int gap_of(input int m);
        return (6 - m < 3) ? 3 : 6 - m;
    endfunction

    function automatic int next_pos(input int raw, input int m, input int prev);
        int mp, c;
        mp = ROWS - gap_of(m);
        c  = (raw > mp) ? raw - mp - 1 : raw;
        if (c < prev - 4) c = prev - 4;
        if (c > prev + 4) c = prev + 4;
        if (c < 0)  c = 0;
        if (c > mp) c = mp;
        return c;
    endfunction

    function automatic logic [15:0] pipe_col(input int pos, input int gap);
        logic [15:0] r;
        for (int b = 0; b < ROWS; b++) r[b] = !(b >= pos && b < pos + gap);
        return r;
    endfunction

    // Column k of a game: SPC lead zeros, then repeating [PIPE_W pipe columns, SPC zeros].
    function automatic int phase(input int k);
        int j;
        if (k < SPC) return -1;
        j = (k - SPC) % (PIPE_W + SPC);
        return (j < PIPE_W) ? j : -1;
    endfunction

    logic [7:0] lfsr_m;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr_m <= 8'hA5;
        else        lfsr_m <= (lfsr_m == 0) ? 8'hA5 : {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};

    bit          m_active, exp_valid, exp_start;
    int          m_k, m_gp, m_cnt;
    logic [15:0] exp_col;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 0; m_k <= 0; m_gp <= 0; m_cnt <= 0;
            exp_col <= 0; exp_valid <= 0; exp_start <= 0;
        end else begin
            exp_valid <= 0;
            exp_start <= 0;
            if (!enable) begin
                m_active <= 0;
                exp_col  <= 0;
            end else if (tick) begin
                exp_valid <= 1;
                if (!m_active) begin
                    m_active <= 1; m_k <= 1; m_cnt <= 0; m_gp <= (ROWS - 6) / 2; exp_col <= 0;
                end else begin
                    m_k <= m_k + 1;
                    if (phase(m_k) == 0) begin
                        m_gp      <= next_pos(int'(lfsr_m[3:0]), int'(mode), m_gp);
                        exp_col   <= pipe_col(next_pos(int'(lfsr_m[3:0]), int'(mode), m_gp), gap_of(int'(mode)));
                        exp_start <= 1;
                    end else if (phase(m_k) < 0) exp_col <= 0;
                    if (phase(m_k) == PIPE_W - 1 && m_cnt < 255) m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("model_column", 32'(column), 32'(exp_col));
            check("model_valid", 32'(column_valid), 32'(exp_valid));
            check("model_start", 32'(pipe_start), 32'(exp_start));
            check("model_gap_pos", 32'(gap_pos), 32'(m_gp));
            check("model_pipes", 32'(pipes), 32'(m_cnt));
        end
    end

    typedef struct {
        logic [3:0]  raw;
        logic [1:0]  mode;
        logic [3:0]  pos;
        logic [15:0] col;
    } vec_t;
    vec_t vt[9];

    initial begin
        int n;
        vt[0] = '{4'd14, 2'd0, 4'd3, 16'hFE07};
        vt[1] = '{4'd1,  2'd0, 4'd1, 16'hFF81};
        vt[2] = '{4'd10, 2'd0, 4'd5, 16'hF81F};
        vt[3] = '{4'd0,  2'd3, 4'd1, 16'hFFF1};
        vt[4] = '{4'd15, 2'd3, 4'd1, 16'hFFF1};
        vt[5] = '{4'd12, 2'd1, 4'd0, 16'hFFE0};
        vt[6] = '{4'd11, 2'd0, 4'd0, 16'hFFC0};
        vt[7] = '{4'd9,  2'd2, 4'd4, 16'hFF0F};
        vt[8] = '{4'd13, 2'd0, 4'd2, 16'hFF03};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_column", 32'(column), 0);
        check("rst_valid", 32'(column_valid), 0);
        check("rst_pipes", 32'(pipes), 0);
        check("rst_gap_pos", 32'(gap_pos), 0);
        check("rst_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'h A5);
        @(posedge clk);
        #1 rst_n = 1;
        chk_en = 1;

        step(1, 1);
        @(negedge clk);
        check("start_column", 32'(column), 0);
        check("start_valid", 32'(column_valid), 1);
        check("start_gap_ref", 32'(gap_pos), 5);
        step(1, 1);
        step(1, 1);
        for (int i = 0; i < 9; i++) begin
            n = 0;
            while (lfsr_m[3:0] != vt[i].raw && n < 600) begin
                step(1, 0);
                n++;
            end
            check("raw_wait", 32'(n < 600), 1);
            mode = vt[i].mode;
            step(1, 1);
            @(negedge clk);
            check("vec_gap_pos", 32'(gap_pos), 32'(vt[i].pos));
            check("vec_column", 32'(column), 32'(vt[i].col));
            check("vec_start", 32'(pipe_start), 1);
            mode = ~vt[i].mode;
            step(1, 1);
            @(negedge clk);
            check("vec_col2_same", 32'(column), 32'(vt[i].col));
            check("vec_col2_start", 32'(pipe_start), 0);
            check("vec_pipes", 32'(pipes), 32'(i + 1));
            repeat (3) step(1, 1);
        end

        step(0, 0);
        repeat (9) step(1, 1);
        @(negedge clk);
        check("drop_pre_start", 32'(pipe_start), 1);
        step(0, 1);
        @(negedge clk);
        check("drop_valid", 32'(column_valid), 0);
        check("drop_column", 32'(column), 0);
        check("drop_pipes_held", 32'(pipes), 1);

        repeat (2000) begin
            if ($urandom_range(0, 199) == 0) step(0, 1'($urandom_range(0, 1)));
            else begin
                if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
                step(1, $urandom_range(0, 9) < 7);
            end
        end

        mode = 0;
        step(0, 0);
        repeat (1503) step(1, 1);
        @(negedge clk);
        check("sat_pipes", 32'(pipes), 255);

        step(0, 0);
        repeat (4) step(1, 1);
        #1 rst_n = 0;
        @(negedge clk);
        check("midrst_column", 32'(column), 0);
        check("midrst_valid", 32'(column_valid), 0);
        check("midrst_pipes", 32'(pipes), 0);
        check("midrst_gap_pos", 32'(gap_pos), 0);
        check("midrst_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'hA5);
        @(posedge clk);
        #1 rst_n = 1;
        step(1, 1);
        @(negedge clk);
        check("restart_valid", 32'(column_valid), 1);
        check("restart_column", 32'(column), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stream_gen.md
Name: pipe_stream_gen

Overview:
- Parametrised successor to the single-pattern pipe generator for the Flappy LED matrix.
- Produces a scrolling stream of ROWS-tall columns, one per scroll tick: pipe columns with a random gap, then empty spacing columns.
- Gap size is set by the difficulty mode; gap movement between consecutive pipes is limited for playability.
- Sits between the game-control FSM (enable, tick, mode) and the column-shift display buffer.

Parameters:
- ROWS, 16, matrix height in LEDs; column width.
- GAP_MAX, 6, gap height at mode 0; must satisfy GAP_MAX <= ROWS/2.
- GAP_MIN, 3, smallest gap allowed at any mode; GAP_MIN >= 1.
- PIPE_WIDTH, 2, columns per pipe.
- SPACING, 3, empty columns between pipes; also the lead-in length after start.
- MAX_STEP, 4, maximum change in gap_pos between consecutive pipes.
- LFSR_W, 8, LFSR width; legal range 5..16.
- SEED, 8'hA5, LFSR reset/reload value; must be nonzero in LFSR_W bits.
- CNT_W, 8, width of pipes_emitted.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  game running; low forces IDLE.
- tick  in  1  one-cycle scroll strobe; requests the next column.
- mode  in  2  difficulty; gap = max(GAP_MAX - mode, GAP_MIN).
- column  out  ROWS  current column; 1 = lit pipe, 0 = open; bit ROWS-1 is the top row.
- column_valid  out  1  one-cycle pulse when column updates.
- pipe_start  out  1  one-cycle pulse coincident with column_valid on the first column of each pipe.
- gap_pos  out  $clog2(ROWS)  bottom row of the current or last gap.
- pipes_emitted  out  CNT_W  completed pipes this game; saturates at all-ones.

Behaviour:
- Reset (async, active-low): all outputs 0, FSM in IDLE, LFSR = SEED, internal counters 0.
- LFSR:
  - Free-running every clock, regardless of enable, so entropy depends on player timing.
  - Fibonacci form, taps from the package table.
  - Any all-zero state reloads SEED on the next clock.
- FSM states: IDLE, LEAD, PIPE, SPACE.
- IDLE: column holds 0.
  - enable=1 and tick=1 -> LEAD.
  - On this transition pipes_emitted clears, the gap_pos reference register clears to (ROWS - GAP_MAX)/2, and the first column (zeros) is emitted.
- LEAD: emits SPACING zero columns in total, counting the one emitted on entry; then -> PIPE on the next tick.
- PIPE entry (the tick that leaves LEAD or SPACE):
  - gap = max(GAP_MAX - mode, GAP_MIN); mode is sampled only at this point.
  - max_pos = ROWS - gap; raw = low $clog2(ROWS) LFSR bits.
  - cand = raw > max_pos ? raw - (max_pos+1) : raw.
  - cand is clamped to within ±MAX_STEP of the previous gap_pos, then to [0, max_pos].
  - Result is registered as gap_pos.
- PIPE: emits PIPE_WIDTH identical columns, with bits [gap_pos+gap-1 : gap_pos] = 0 and all others 1.
  - The first of these columns asserts pipe_start.
  - After the last column: pipes_emitted +1 (saturating), -> SPACE.
- SPACE: emits SPACING zero columns, then -> PIPE.
- Timing:
  - Ticks are counted only while enabled; no column changes without a tick.
  - Latency: tick sampled at edge N -> column and column_valid valid after edge N+1; column holds until the next update.
  - Back-to-back ticks on every cycle are legal and give one column per cycle.
- enable low: at the next edge go to IDLE, column = 0, column_valid = 0.
  - gap_pos and pipes_emitted hold, so the final score stays readable.
  - enable low with a simultaneous tick: enable wins and no column is emitted.
- mode changes mid-pipe take effect at the next pipe only.
- Reset asserted mid-pipe: immediate return to reset values; no partial-pipe completion.

Decomposition:
- Package pipe_gen_pkg: state enum (IDLE, LEAD, PIPE, SPACE) and the LFSR tap table/function for widths 5..16.
- Sub-module lfsr_gen (params LFSR_W, SEED): free-running LFSR with zero-lock reload.
- The top module holds the FSM, counters, gap computation and column build.

Test Plan (defaults; mode=0, so gap=6 and max_pos=10):
- Reset low mid-run -> column=0, pipes_emitted=0, FSM IDLE, LFSR=8'hA5 on the following cycle.
- enable=1, ticks every cycle -> 3 zero columns, then 2 identical pipe columns (first with pipe_start=1), then 3 zero columns, repeating; pipes_emitted=1 after the 5th column.
- Force raw=14, previous gap_pos=5 -> cand = 14 - 11 = 3 -> gap_pos=3; column = 16'b1111111000000111.
- Force raw=10, previous gap_pos=1 -> gap_pos clamped to 1 + 4 = 5.
- mode=3 -> gap = max(6-3, 3) = 3, 3 zero bits; mode changed during PIPE -> current pipe keeps the old gap.
- enable dropped together with a tick during PIPE -> no column_valid, column=0 next cycle, pipes_emitted held; 300 pipes -> counter saturates at 255.
